switch_reader: RTL and testbench
================================

SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set stable-input cycles required before a debounced value updates (10 ms at 50 MHz).
REQ-002 Parameter TICK_CYCLES, default 25000000, SHALL set the step_tick period in clk cycles (0.5 s at 50 MHz).
REQ-003 clk  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sw_raw  input  2  SHALL carry the unsynchronised slide switches selecting the LED mode.
REQ-006 btn_raw  input  1  SHALL carry the unsynchronised run/pause push button, high = pressed.
REQ-007 mode  output  2  SHALL carry the registered mode code for the LED pattern block.
REQ-008 mode_chg  output  1  SHALL pulse high for one cycle when mode takes a new value.
REQ-009 sw_illegal  output  1  SHALL be high while the debounced switch code is 2'b11.
REQ-010 run  output  1  SHALL indicate step_tick generation is enabled.
REQ-011 btn_press  output  1  SHALL pulse high for one cycle per debounced button press.
REQ-012 step_tick  output  1  SHALL pulse high for one cycle per pattern step, used as the LED block's clock enable.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchroniser before any other logic.
REQ-014 Debounce SHALL use one counter for the 2-bit switch vector and one for the button; counter clears whenever the synchronised value equals the stable value.
REQ-015 When the synchronised value differs from the stable value for DB_CYCLES consecutive cycles, the stable value SHALL update and the counter SHALL clear; any bounce back before then clears the counter without update.
REQ-016 Latency raw edge to stable update SHALL be exactly DB_CYCLES+2 cycles for a clean edge.
REQ-017 A change on either switch bit mid-count SHALL restart the shared switch counter (vector compared as a whole).
REQ-018 Stable switch codes 00, 01, 10 SHALL load mode; code 11 SHALL leave mode unchanged and set sw_illegal.
REQ-019 mode_chg SHALL assert in the same cycle mode first shows the new value; no pulse if the decoded value equals the current mode.
REQ-020 btn_press SHALL pulse on the debounced 0->1 transition only; release produces no pulse.
REQ-021 run SHALL toggle on each btn_press.
REQ-022 Tick counter (width clog2(TICK_CYCLES)) SHALL increment while run=1, hold while run=0, and wrap TICK_CYCLES-1 -> 0 with step_tick high in the wrap cycle.
REQ-023 mode_chg SHALL clear the tick counter to 0 and suppress step_tick that cycle (mode_chg wins over wrap).
REQ-024 btn_press coinciding with wrap SHALL still emit that step_tick; the new run value applies from the next cycle.

Reset
REQ-025 Reset low SHALL immediately force: mode=2'b00, mode_chg=0, sw_illegal=0, run=1, btn_press=0, step_tick=0, tick and debounce counters=0, stable switch=00, stable button=0, synchronisers=0.
REQ-026 Reset mid-debounce or mid-tick SHALL discard progress; after release, a held switch value other than 00 is re-debounced and produces one mode_chg.
REQ-027 Release SHALL be synchronised by the surrounding reset logic; this block only requires asynchronous assertion.

Structure
REQ-028 A shared package SHALL hold mode codes MODE_SHR=2'b00, MODE_CNT=2'b01, MODE_ALT=2'b10, MODE_RSV=2'b11 and default DB_CYCLES/TICK_CYCLES.
REQ-029 One sub-module, debounce (parameters WIDTH, DB_CYCLES; sync + counter + stable register), SHALL be instantiated twice (WIDTH=2 switches, WIDTH=1 button).

Verification (DB_CYCLES=4, TICK_CYCLES=8)
REQ-030 sw_raw 00->10 clean, held -> mode=10 and mode_chg one pulse exactly 6 cycles after the edge.
REQ-031 sw_raw toggles 01/00 every 3 cycles for 20 cycles, then settles 01 -> no mode change during bouncing; one mode_chg 6 cycles after settling.
REQ-032 sw_raw=11 held 10 cycles -> sw_illegal=1 and mode holds previous value, no mode_chg; back to 01 -> sw_illegal=0, mode=01.
REQ-033 run=1, no input changes -> step_tick every 8 cycles; button press 10 cycles -> one btn_press, run=0, step_tick stops; second press -> run=1, ticks resume from held count.
REQ-034 Mode change landing on tick count 7 -> mode_chg high, step_tick low that cycle, next step_tick 8 cycles later.
REQ-035 reset pulsed low mid-debounce with sw_raw=10 -> outputs at reset values asynchronously; after release mode=10 after 6 cycles with one mode_chg.

Source files
------------

// File: rtl/switch_reader_pkg.sv
// Shared constants for the switch reader: LED mode codes and default timing.
package switch_reader_pkg;

    localparam logic [1:0] MODE_SHR = 2'b00;
    localparam logic [1:0] MODE_CNT = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // 10 ms debounce and 0.5 s pattern step at 50 MHz
    localparam int DB_CYCLES_DEF   = 500000;
    localparam int TICK_CYCLES_DEF = 25000000;

    // The reserved code never reaches the LED pattern block
    function automatic logic mode_legal(input logic [1:0] code);
        return code != MODE_RSV;
    endfunction

endpackage

// File: rtl/switch_reader_debounce.sv
// Two-flop synchroniser followed by a stable-value debouncer.
// The input vector is compared as a whole: any change of the synchronised
// value restarts the count, so only a value held for DB_CYCLES consecutive
// cycles is accepted. stable_d_o exposes the next stable value so the parent
// can react in the same cycle the stable value updates.
module debounce
    import switch_reader_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] stable_d_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    run_len;

    // Count consecutive cycles of one differing value; accept it on the last
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        run_len  = '0;
        if (sync2_q != stable_q) begin
            run_len = (sync2_q != prev_q) ? '0 : cnt_q;
            if (run_len == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = run_len + CW'(1);
            end
        end
    end

    // Synchroniser, change detector and debounce state
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o   = stable_q;
    assign stable_d_o = stable_d;

endmodule

// File: rtl/switch_reader.sv
// Switch/button front end for the LED pattern block: debounces the mode
// switches and run/pause button, holds the mode and run state, and produces
// the pattern step enable.
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] sw_raw_i,
    input  logic       btn_raw_i,
    output logic [1:0] mode_o,
    output logic       mode_chg_o,
    output logic       sw_illegal_o,
    output logic       run_o,
    output logic       btn_press_o,
    output logic       step_tick_o
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [1:0]    sw_stable;
    logic [1:0]    sw_stable_d;
    logic          btn_stable;
    logic          btn_stable_d;

    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic          mode_chg_q;
    logic          mode_chg_d;
    logic          btn_press_q;
    logic          btn_press_d;
    logic          run_q;
    logic          run_d;
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick_wrap;

    debounce #(
        .WIDTH     (2),
        .DB_CYCLES (DB_CYCLES)
    ) u_db_sw (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .raw_i      (sw_raw_i),
        .stable_o   (sw_stable),
        .stable_d_o (sw_stable_d)
    );

    debounce #(
        .WIDTH     (1),
        .DB_CYCLES (DB_CYCLES)
    ) u_db_btn (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .raw_i      (btn_raw_i),
        .stable_o   (btn_stable),
        .stable_d_o (btn_stable_d)
    );

    // Load a new legal mode in the same edge the debounced switches settle
    always_comb begin
        mode_d     = mode_q;
        mode_chg_d = 1'b0;
        if (mode_legal(sw_stable_d) && (sw_stable_d != mode_q)) begin
            mode_d     = sw_stable_d;
            mode_chg_d = 1'b1;
        end
    end

    assign btn_press_d = btn_stable_d & ~btn_stable;

    // run flips after the press cycle, so a press never cancels the tick it meets
    assign run_d = run_q ^ btn_press_q;

    assign tick_wrap = run_q && (tick_cnt_q == TICK_LAST);

    // Step counter: a mode change restarts the pattern period from zero
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (mode_chg_q) begin
            tick_cnt_d = '0;
        end else if (run_q) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        end
    end

    // Mode, run and step state
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_q      <= MODE_SHR;
            mode_chg_q  <= 1'b0;
            btn_press_q <= 1'b0;
            run_q       <= 1'b1;
            tick_cnt_q  <= '0;
        end else begin
            mode_q      <= mode_d;
            mode_chg_q  <= mode_chg_d;
            btn_press_q <= btn_press_d;
            run_q       <= run_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign mode_o       = mode_q;
    assign mode_chg_o   = mode_chg_q;
    assign sw_illegal_o = (sw_stable == MODE_RSV);
    assign run_o        = run_q;
    assign btn_press_o  = btn_press_q;
    assign step_tick_o  = tick_wrap & ~mode_chg_q;

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboard bench for switch_reader with DB_CYCLES=4, TICK_CYCLES=8.
// Stimulus pushes the cycle (and mode) at which each mode_chg, btn_press and
// step_tick pulse must appear; a negedge monitor pops and compares them.
module tb_switch_reader;

    logic       clk;
    logic       reset_n;
    logic [1:0] sw_raw;
    logic       btn_raw;
    logic [1:0] mode;
    logic       mode_chg;
    logic       sw_illegal;
    logic       run;
    logic       btn_press;
    logic       step_tick;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } mode_exp_t;

    mode_exp_t mode_exp[$];
    int        btn_exp[$];
    int        tick_exp[$];

    int cyc     = 0;
    int n_chk   = 0;
    int n_pass  = 0;
    bit tick_en = 1'b0;

    switch_reader #(
        .DB_CYCLES   (4),
        .TICK_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .sw_raw_i     (sw_raw),
        .btn_raw_i    (btn_raw),
        .mode_o       (mode),
        .mode_chg_o   (mode_chg),
        .sw_illegal_o (sw_illegal),
        .run_o        (run),
        .btn_press_o  (btn_press),
        .step_tick_o  (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (mode_chg) begin
                chk("mode_chg_pending", 32'(mode_exp.size() != 0), 1);
                if (mode_exp.size() != 0) begin
                    mode_exp_t e;
                    e = mode_exp.pop_front();
                    chk("mode_chg_cyc", cyc, e.cyc);
                    chk("mode_chg_val", 32'(mode), 32'(e.val));
                end
            end
            if (btn_press) begin
                chk("btn_press_pending", 32'(btn_exp.size() != 0), 1);
                if (btn_exp.size() != 0) chk("btn_press_cyc", cyc, btn_exp.pop_front());
            end
            if (tick_en && step_tick) begin
                chk("tick_pending", 32'(tick_exp.size() != 0), 1);
                if (tick_exp.size() != 0) chk("tick_cyc", cyc, tick_exp.pop_front());
            end
        end
    end

    initial begin
        int r, p, q, s, b, c, d, m, g, f, z;
        reset_n = 1'b0;
        sw_raw  = 2'b00;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_mode", 32'(mode), 0);
        chk("rst_mode_chg", 32'(mode_chg), 0);
        chk("rst_sw_illegal", 32'(sw_illegal), 0);
        chk("rst_run", 32'(run), 1);
        chk("rst_btn_press", 32'(btn_press), 0);
        chk("rst_step_tick", 32'(step_tick), 0);

        // free-running ticks from a cleared counter
        r = cyc;
        reset_n = 1'b1;
        tick_en = 1'b1;
        tick_exp.push_back(r + 7);
        tick_exp.push_back(r + 15);
        tick_exp.push_back(r + 23);
        wait_until(r + 24);
        chk("tick_drain_free", tick_exp.size(), 0);

        // pause: counter holds at 7 with run low, no tick
        p = cyc;
        btn_raw = 1'b1;
        btn_exp.push_back(p + 6);
        wait_until(p + 8);
        chk("run_paused", 32'(run), 0);
        wait_until(p + 10);
        btn_raw = 1'b0;
        wait_until(p + 30);
        chk("run_still_paused", 32'(run), 0);

        // resume: held count 7 ticks as soon as run returns
        q = cyc;
        btn_raw = 1'b1;
        btn_exp.push_back(q + 6);
        tick_exp.push_back(q + 7);
        tick_exp.push_back(q + 15);
        tick_exp.push_back(q + 23);
        wait_until(q + 8);
        chk("run_resumed", 32'(run), 1);
        wait_until(q + 10);
        btn_raw = 1'b0;
        wait_until(q + 24);
        chk("tick_drain_resume", tick_exp.size(), 0);
        tick_en = 1'b0;

        // clean switch edge 00 -> 10
        s = cyc;
        sw_raw = 2'b10;
        mode_exp.push_back('{s + 6, 2'b10});
        wait_until(s + 7);
        chk("mode_after_edge", 32'(mode), 2);
        chk("mode_chg_single", 32'(mode_chg), 0);

        // bouncing 01/00 every 3 cycles, then settle on 01
        wait_until(s + 10);
        b = cyc;
        for (int i = 0; i < 6; i++) begin
            sw_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
            repeat (3) @(negedge clk);
        end
        chk("mode_during_bounce", 32'(mode), 2);
        sw_raw = 2'b01;
        mode_exp.push_back('{b + 24, 2'b01});
        wait_until(b + 26);
        chk("mode_after_settle", 32'(mode), 1);
        z = b + 25;

        // reserved code 11 holds mode and flags illegal
        c = cyc;
        sw_raw = 2'b11;
        wait_until(c + 10);
        chk("illegal_set", 32'(sw_illegal), 1);
        chk("illegal_mode_hold", 32'(mode), 1);
        sw_raw = 2'b01;
        wait_until(c + 17);
        chk("illegal_clear", 32'(sw_illegal), 0);
        chk("illegal_back_mode", 32'(mode), 1);

        // mode change landing on tick count 7 suppresses that tick
        d = cyc + 1;
        while (((d + 6 - z) % 8) != 7) d++;
        wait_until(d);
        m = d + 6;
        tick_en = 1'b1;
        sw_raw = 2'b10;
        mode_exp.push_back('{m, 2'b10});
        tick_exp.push_back(m + 8);
        wait_until(m);
        chk("wrap_mode_chg", 32'(mode_chg), 1);
        chk("wrap_tick_suppressed", 32'(step_tick), 0);
        wait_until(m + 9);
        chk("tick_drain_wrap", tick_exp.size(), 0);
        tick_en = 1'b0;

        // reset in the middle of a debounce
        g = cyc;
        sw_raw = 2'b01;
        mode_exp.push_back('{g + 6, 2'b01});
        wait_until(g + 8);
        chk("pre_reset_mode", 32'(mode), 1);
        sw_raw = 2'b10;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_mode", 32'(mode), 0);
        chk("async_rst_mode_chg", 32'(mode_chg), 0);
        chk("async_rst_run", 32'(run), 1);
        chk("async_rst_tick", 32'(step_tick), 0);
        repeat (3) @(negedge clk);
        f = cyc;
        reset_n = 1'b1;
        mode_exp.push_back('{f + 6, 2'b10});
        wait_until(f + 10);
        chk("post_reset_mode", 32'(mode), 2);

        chk("mode_sb_empty", mode_exp.size(), 0);
        chk("btn_sb_empty", btn_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
